// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl
// Sequential unsigned multiplier. It uses a shift-and-add datapath with a
// three-state controller (IDLE -> RUN -> DONE -> IDLE). An accepted Start
// captures A and B. RUN then takes exactly WIDTH cycles, one multiplier bit
// per cycle. The result is presented with a single-cycle Done pulse.
//
// Ports
//   Clk      in   1        rising-edge clock
//   Rst_n    in   1        synchronous active-low reset
//   Start    in   1        begin a multiplication (honoured only in IDLE)
//   A        in   WIDTH    unsigned multiplicand, captured on accepted Start
//   B        in   WIDTH    unsigned multiplier, captured on accepted Start
//   Busy     out  1        registered, high for the WIDTH cycles of work
//   Done     out  1        registered single-cycle pulse, Product valid
//   Product  out  2*WIDTH  A*B, held until the next result is presented
//
// All outputs are registered copies of the state decode. Busy is therefore
// high in the cycles after edges 1..WIDTH, and Done is high in the cycle
// after edge WIDTH+1. This is counted from the accepting edge 0.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] acc_r;      // {high, low}; low initially holds B
  logic               carry_r;    // top bit of {carry, high, low}
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH:0]     sum_s;      // (WIDTH+1)-bit sum, carry out in MSB
  logic [WIDTH:0]     chain_s;    // ripple carries between bit slices
  logic [1:0]         fa_s;

  // {carry, sum} of a half adder
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // {carry, sum} of a full adder: two half adders with OR-ed carries
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    logic [1:0] h0;
    logic [1:0] h1;
    h0 = half_add(x, y);
    h1 = half_add(h0[0], cin);
    return {h0[1] | h1[1], h1[0]};
  endfunction

  // Ripple-carry adder: high half + (multiplier LSB ? multiplicand : 0).
  // The carry bit is always zero after a shift. Using it as the carry-in
  // keeps the chain uniform without changing the sum.
  always_comb begin
    addend_s = '0;
    sum_s    = '0;
    chain_s  = '0;
    fa_s     = 2'b00;
    if (acc_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = '0;
    end
    chain_s[0] = carry_r;
    for (int i = 0; i < WIDTH; i++) begin
      fa_s           = full_add(acc_r[WIDTH+i], addend_s[i], chain_s[i]);
      sum_s[i]       = fa_s[0];
      chain_s[i+1]   = fa_s[1];
    end
    sum_s[WIDTH] = chain_s[WIDTH];
  end

  // Next-state logic for the controller
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        // The step performed with counter = 1 is the last one
        if (cnt_r == CW'(1)) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r <= IDLE;
      mcand_r <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        IDLE: begin
          if (Start) begin
            mcand_r <= A;
            acc_r   <= {{WIDTH{1'b0}}, B};
            carry_r <= 1'b0;
            cnt_r   <= CW'(WIDTH);
          end
        end
        RUN: begin
          // Shift {carry_out, sum, low} right by one. The new carry is 0,
          // and sum[0] moves into the low half.
          {carry_r, acc_r} <= {1'b0, sum_s, acc_r[WIDTH-1:1]};
          cnt_r            <= cnt_r - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs; Product is refreshed only while in DONE
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Product <= '0;
    end else begin
      Busy <= (state_r == RUN);
      Done <= (state_r == DONE);
      if (state_r == DONE) begin
        Product <= acc_r;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl with WIDTH=4 and WIDTH=8 instances.
// The driver models which Start edges are accepted: at most one every
// WIDTH+2 edges, and any edge after a reset. For each accepted Start it
// pushes the expected product and the edge after which Done must be seen.
// A negedge monitor pops and compares entries, and checks Busy, Done
// exclusivity and Product hold.
module tb_shift_add_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  prod4;
  logic [15:0] prod8;

  always #5 clk = ~clk;

  shift_add_mult_ctrl #(.WIDTH(4)) u_dut4 (
    .Clk(clk), .Rst_n(rst_n), .Start(start4), .A(a4), .B(b4),
    .Busy(busy4), .Done(done4), .Product(prod4)
  );

  shift_add_mult_ctrl #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Rst_n(rst_n), .Start(start8), .A(a8), .B(b8),
    .Busy(busy8), .Done(done8), .Product(prod8)
  );

  typedef struct {
    longint unsigned prod;
    int              due;
  } exp_t;

  exp_t            q4[$];
  exp_t            q8[$];
  exp_t            pop4, pop8, ent;
  int              edge_n   = 0;
  int              next_ok4 = 0;
  int              next_ok8 = 0;
  longint unsigned hold4    = 0;
  longint unsigned hold8    = 0;
  bit              armed    = 1'b0;
  int              checks   = 0;
  int              failures = 0;
  logic            busy_exp;

  function automatic void chk(input string nm, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", nm, edge_n, act, req);
    end
  endfunction

  // One clock edge for both instances, with acceptance modelled per instance
  task automatic tick(input logic r, input logic s4, input logic [3:0] xa4, input logic [3:0] xb4,
                      input logic s8, input logic [7:0] xa8, input logic [7:0] xb8);
    rst_n = r; start4 = s4; a4 = xa4; b4 = xb4; start8 = s8; a8 = xa8; b8 = xb8;
    @(posedge clk);
    edge_n++;
    if (!r) begin
      q4.delete(); q8.delete();
      next_ok4 = edge_n + 1; next_ok8 = edge_n + 1;
      hold4 = 0; hold8 = 0;
      armed = 1'b1;
    end else begin
      if (s4 && edge_n >= next_ok4) begin
        ent.prod = longint'(xa4) * longint'(xb4);
        ent.due  = edge_n + 4 + 1;
        q4.push_back(ent);
        next_ok4 = edge_n + 4 + 2;
      end
      if (s8 && edge_n >= next_ok8) begin
        ent.prod = longint'(xa8) * longint'(xb8);
        ent.due  = edge_n + 8 + 1;
        q8.push_back(ent);
        next_ok8 = edge_n + 8 + 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic t4(input logic r, input logic s, input logic [3:0] xa, input logic [3:0] xb);
    tick(r, s, xa, xb, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic t8(input logic s, input logic [7:0] xa, input logic [7:0] xb);
    tick(1'b1, 1'b0, 4'd0, 4'd0, s, xa, xb);
  endtask

  task automatic idle4(input int n);
    for (int k = 0; k < n; k++) t4(1'b1, 1'b0, 4'd0, 4'd0);
  endtask

  // Monitor: compares DUT outputs against the scoreboard away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      // WIDTH=4 instance
      busy_exp = (q4.size() > 0) && (edge_n >= q4[0].due - 4) && (edge_n <= q4[0].due - 1);
      chk("busy4", busy4, busy_exp);
      chk("busy_done_excl4", busy4 & done4, 0);
      if (done4 === 1'b1) begin
        if (q4.size() == 0) begin
          chk("unexpected_done4", 1, 0);
        end else begin
          pop4 = q4.pop_front();
          chk("done_edge4", edge_n, pop4.due);
          chk("product4", prod4, pop4.prod);
          hold4 = pop4.prod;
        end
      end else if (q4.size() > 0 && edge_n >= q4[0].due) begin
        chk("done_timeout4", 0, 1);
        pop4 = q4.pop_front();
      end
      chk("hold4", prod4, hold4);
      // WIDTH=8 instance
      busy_exp = (q8.size() > 0) && (edge_n >= q8[0].due - 8) && (edge_n <= q8[0].due - 1);
      chk("busy8", busy8, busy_exp);
      chk("busy_done_excl8", busy8 & done8, 0);
      if (done8 === 1'b1) begin
        if (q8.size() == 0) begin
          chk("unexpected_done8", 1, 0);
        end else begin
          pop8 = q8.pop_front();
          chk("done_edge8", edge_n, pop8.due);
          chk("product8", prod8, pop8.prod);
          hold8 = pop8.prod;
        end
      end else if (q8.size() > 0 && edge_n >= q8[0].due) begin
        chk("done_timeout8", 0, 1);
        pop8 = q8.pop_front();
      end
      chk("hold8", prod8, hold8);
    end
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout edge=%0d got=running expected=finished", edge_n);
    $fatal(1, "time limit");
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0;
    a4 = 4'd0; b4 = 4'd0; a8 = 8'd0; b8 = 8'd0;
    @(negedge clk);
    t4(1'b0, 1'b0, 4'd0, 4'd0);
    t4(1'b0, 1'b1, 4'd15, 4'd15);   // Start ignored under reset
    // Directed products, including the maximum and a zero operand
    t4(1'b1, 1'b1, 4'd15, 4'd15); idle4(7);
    t4(1'b1, 1'b1, 4'd0,  4'd9);  idle4(6);
    t4(1'b1, 1'b1, 4'd13, 4'd11); idle4(6);
    // New Start and operands during RUN must be ignored
    t4(1'b1, 1'b1, 4'd6, 4'd7);
    for (int k = 0; k < 5; k++) t4(1'b1, 1'b1, 4'd3, 4'd3);
    idle4(4);
    // Reset at the second RUN edge aborts the operation; restart at once
    t4(1'b1, 1'b1, 4'd9, 4'd9);
    t4(1'b1, 1'b0, 4'd0, 4'd0);
    t4(1'b0, 1'b0, 4'd0, 4'd0);
    t4(1'b1, 1'b1, 4'd5, 4'd5); idle4(8);
    // Start held high: one result every six cycles
    for (int k = 0; k < 30; k++) t4(1'b1, 1'b1, 4'd2, 4'd3);
    idle4(8);
    // Exhaustive WIDTH=4 sweep with random Start noise while busy
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        t4(1'b1, 1'b1, 4'(a), 4'(b));
        for (int j = 0; j < 5; j++) t4(1'b1, 1'($urandom()), 4'($urandom()), 4'($urandom()));
      end
    end
    idle4(8);
    // WIDTH=8: corner pairs, then 1000 random pairs with Start noise while busy
    t8(1'b1, 8'd255, 8'd255); for (int j = 0; j < 9; j++) t8(1'b0, 8'd0, 8'd0);
    t8(1'b1, 8'd0,   8'd200); for (int j = 0; j < 9; j++) t8(1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 1000; i++) begin
      t8(1'b1, 8'($urandom()), 8'($urandom()));
      for (int j = 0; j < 9; j++) t8(1'($urandom()), 8'($urandom()), 8'($urandom()));
    end
    for (int j = 0; j < 14; j++) t8(1'b0, 8'd0, 8'd0);
    chk("drain4", q4.size(), 0);
    chk("drain8", q8.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_ctrl.md
SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 Clk  input  1  rising-edge clock, the only clock.
REQ-003 Rst_n  input  1  synchronous, active-low reset, sampled on rising Clk.
REQ-004 Start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 A  input  WIDTH  unsigned multiplicand; captured on the accepted Start edge.
REQ-006 B  input  WIDTH  unsigned multiplier; captured on the accepted Start edge.
REQ-007 Busy  output  1  high while a multiplication is in progress (state RUN).
REQ-008 Done  output  1  single-cycle pulse; Product is valid in that cycle.
REQ-009 Product  output  2*WIDTH  unsigned result A*B; held stable from Done until the next accepted Start.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 IDLE with Start=1 SHALL go to RUN on that edge:
  - latch A into the multiplicand register;
  - load B into the low half of the accumulator and clear the high half plus carry bit;
  - load the step counter with WIDTH.
REQ-012 IDLE with Start=0 SHALL remain in IDLE with all registers unchanged.
REQ-013 Each RUN cycle SHALL perform one step:
  - if accumulator bit 0 = 1, add the multiplicand to the high half as a (WIDTH+1)-bit sum (carry out kept);
  - otherwise add zero;
  - shift the {carry, high, low} accumulator right by 1;
  - decrement the counter.
REQ-014 The adder SHALL be a ripple chain of 1-bit full adders, each built from two half adders and an OR gate on the carries.
REQ-015 RUN SHALL last exactly WIDTH cycles regardless of operand values (zero operands included); after the step where counter = 1, the FSM SHALL go to DONE.
REQ-016 DONE SHALL last one cycle with Done=1, then go to IDLE unconditionally.
REQ-017 In DONE, Product SHALL equal the 2*WIDTH-bit accumulator. Product SHALL update only on entry to DONE.
REQ-018 Latency: with Start accepted at edge 0, Done SHALL be high in the cycle after edge WIDTH+1. The next Start SHALL be accepted no earlier than edge WIDTH+2, giving a throughput of 1 result per WIDTH+2 cycles.
REQ-019 Start during RUN or DONE SHALL be ignored: no restart, no queueing, and A/B changes have no effect.
REQ-020 Busy SHALL be 1 only in RUN. Busy and Done SHALL never be high together.
REQ-021 Arithmetic SHALL be unsigned with no overflow: max (2^WIDTH-1)^2 fits in 2*WIDTH bits, and the carry bit is consumed by the next shift.

Reset
REQ-022 Rst_n=0 at a rising edge SHALL force:
  - state to IDLE;
  - Busy=0, Done=0, Product=0;
  - accumulator, multiplicand, counter and carry to 0.
REQ-023 Reset SHALL take priority over Start and over any in-progress RUN or DONE. An aborted operation SHALL produce no Done pulse.
REQ-024 After Rst_n returns high, a Start in the first cycle SHALL be accepted normally.

Verification
REQ-025 WIDTH=4, A=15, B=15, Start pulse at edge 0 -> Busy high for 4 cycles, Done in the cycle after edge 5, Product=225.
REQ-026 WIDTH=4, A=0, B=9 -> Busy still high for 4 cycles, Done after edge 5, Product=0. Repeat with A=13, B=11 -> Product=143.
REQ-027 WIDTH=4, A=6, B=7 started; during RUN drive Start=1, A=3, B=3 -> ignored; Product=42, with a single Done pulse.
REQ-028 WIDTH=4, Rst_n=0 at edge 2 of RUN -> next cycle Busy=0, Done=0, Product=0; no Done follows. Then A=5, B=5 -> Product=25.
REQ-029 WIDTH=4, Start held high continuously with A=2, B=3 -> Product=6 every 6 cycles, Done pulses exactly 6 cycles apart, and Product is stable between pulses.
REQ-030 Random sweep, WIDTH=4 exhaustive (256 pairs) and WIDTH=8 with 1000 random pairs -> Product equals the A*B reference in every case.
